// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// Signals: start/bin_in (request side), ready/done (handshake status),
// overflow and number_0..3 (registered result digits, ones..thousands).
interface bin2bcd_seq_if #(
    parameter int BIN_WIDTH = 14
);
    logic                 start;
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 ready;
    logic                 done;
    logic                 overflow;
    logic [3:0]           number_0;
    logic [3:0]           number_1;
    logic [3:0]           number_2;
    logic [3:0]           number_3;

    // Requester: drives the request, observes status and result.
    modport master (
        output start, bin_in,
        input  ready, done, overflow, number_0, number_1, number_2, number_3
    );

    // Converter: accepts the request, drives status and result.
    modport slave (
        input  start, bin_in,
        output ready, done, overflow, number_0, number_1, number_2, number_3
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding a 4-digit display.
// Latency: done and new digits BIN_WIDTH+2 edges after the accepting edge (edge
// counted as 1); ready only in IDLE, so a start while busy is ignored, not queued.
// Ports: clk, reset (sync, active-high), bus (bin2bcd_seq_if.slave: start, bin_in,
// ready, done, overflow, number_0..3). Macro BIN2BCD_BLANK_EN enables
// leading-zero blanking (blank code 4'hF); default build emits plain BCD.
module bin2bcd_seq #(
    parameter int BIN_WIDTH = 14
) (
    input logic           clk,
    input logic           reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BIN_WIDTH-1:0] shift_reg;
    logic [15:0]          scratch;
    logic [15:0]          adj;
    logic [15:0]          disp;
    logic [CW-1:0]        cnt;
    logic                 ovf_pend;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake
    always_comb begin
        state_nxt = state;
        bus.ready = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_nxt = LOAD;
                end
            end
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would reach >=10 after the shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display value: saturate to 9999 on overflow; the scratch register only
    // holds four digits, so the out-of-range flag is taken from the captured
    // value rather than from a carry out of the BCD register.
    always_comb begin
        disp = ovf_pend ? 16'h9999 : scratch;
`ifdef BIN2BCD_BLANK_EN
        if (!ovf_pend && disp[15:12] == 4'd0) begin
            disp[15:12] = 4'hF;
            if (disp[11:8] == 4'd0) begin
                disp[11:8] = 4'hF;
                if (disp[7:4] == 4'd0) begin
                    disp[7:4] = 4'hF;
                end
            end
        end
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg    <= '0;
            scratch      <= '0;
            cnt          <= '0;
            ovf_pend     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.number_0 <= 4'd0;
            bus.number_1 <= 4'd0;
            bus.number_2 <= 4'd0;
            bus.number_3 <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= bus.bin_in;
                        scratch   <= '0;
                        cnt       <= '0;
                        ovf_pend  <= 32'(bus.bin_in) > 32'd9999;
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {adj, shift_reg} << 1;
                    cnt                  <= cnt + CW'(1);
                end
                LOAD: begin
                    bus.number_0 <= disp[3:0];
                    bus.number_1 <= disp[7:4];
                    bus.number_2 <= disp[11:8];
                    bus.number_3 <= disp[15:12];
                    bus.overflow <= ovf_pend;
                    bus.done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner values, randomized
// conversions, continuous-start throughput and mid-conversion reset, all checked
// against an arithmetic decimal model.
module tb_bin2bcd_seq;
    localparam int W = 14;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bin2bcd_seq_if #(.BIN_WIDTH(W)) bus ();

    bin2bcd_seq #(.BIN_WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {overflow, d3, d2, d1, d0} from the decimal value.
    function automatic logic [31:0] exp_of(input int v);
        logic [3:0] d[4];
        if (v > 9999) begin
            return {15'd0, 1'b1, 16'h9999};
        end
        d[0] = 4'(v % 10);
        d[1] = 4'((v / 10) % 10);
        d[2] = 4'((v / 100) % 10);
        d[3] = 4'(v / 1000);
`ifdef BIN2BCD_BLANK_EN
        for (int k = 3; k >= 1; k--) begin
            if (d[k] != 4'd0) break;
            d[k] = 4'hF;
        end
`endif
        return {15'd0, 1'b0, d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [31:0] observed();
        return {15'd0, bus.overflow, bus.number_3, bus.number_2, bus.number_1, bus.number_0};
    endfunction

    // One full conversion; optionally pokes start while busy, which must be ignored.
    task automatic convert(input int v, input bit poke_busy);
        int n;
        n = 0;
        while (!bus.ready && n < 40) begin
            step();
            n++;
        end
        check("ready_before", bus.ready, 1);
        bus.start  = 1'b1;
        bus.bin_in = W'(v);
        step();
        bus.start  = 1'b0;
        bus.bin_in = W'($urandom);
        check("busy_ready", bus.ready, 0);
        n = 1;  // accepting edge counts as edge 1
        while (n < 40) begin
            if (poke_busy && n == 4) begin
                bus.start  = 1'b1;
                bus.bin_in = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            step();
            n++;
            if (bus.done) break;
        end
        check("latency", n, W + 2);
        check("result", observed(), exp_of(v));
        step();
        check("done_pulse", bus.done, 0);
        step();
        check("hold", observed(), exp_of(v));
    endtask

    initial begin
        int q[$];
        int last_acc;
        int n;
        int dones;
        int v;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        step();
        step();
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_result", observed(), 32'd0);
        reset = 1'b0;

        // Directed corner values
        convert(1234, 1'b0);
        convert(0, 1'b0);
        convert(9999, 1'b0);
        convert(10000, 1'b0);
        convert(16383, 1'b0);
        convert(305, 1'b1);
        convert(7, 1'b1);

        // Randomized conversions with busy-time start pokes
        for (int i = 0; i < 12; i++) begin
            v = (i % 2 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 16383));
            convert(v, i[0]);
        end

        // start held high, bin_in changing every cycle
        bus.start = 1'b1;
        last_acc  = -1;
        for (int c = 0; c < 100; c++) begin
            bus.bin_in = W'($urandom);
            if (bus.ready) begin
                q.push_back(int'(bus.bin_in));
                if (last_acc >= 0) check("acc_period", c - last_acc, W + 2);
                last_acc = c;
            end
            step();
            if (bus.done) begin
                check("cont_has_pending", q.size() != 0, 1);
                if (q.size() != 0) check("cont_result", observed(), exp_of(q.pop_front()));
            end
        end
        bus.start = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
            if (bus.done) check("drain_result", observed(), exp_of(q.pop_front()));
        end
        check("no_drop", q.size(), 0);

        // Reset five cycles into a conversion of 4321
        n = 0;
        while (!bus.ready && n < 40) begin
            step();
            n++;
        end
        bus.start  = 1'b1;
        bus.bin_in = W'(4321);
        step();
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            dones += int'(bus.done);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", bus.ready, 1);
        check("abort_result", observed(), 32'd0);
        for (int i = 0; i < 20; i++) begin
            dones += int'(bus.done);
            step();
        end
        check("abort_no_done", dones, 0);
        check("abort_hold", observed(), 32'd0);

        // Start in the very first cycle after reset deasserts
        reset = 1'b1;
        step();
        reset = 1'b0;
        convert(42, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
